spectro_frame_serializer: RTL and testbench

//  Sits downstream of the per-channel impulse counters. Every frame period it:
//   - freezes the counters and lets their async outputs settle
//   - snapshots all counts and overflow flags, then clears the counters
//   - streams one 16-bit word per channel over a valid/ready interface
//  The result is one spectrogram column per frame for the readout logic.

---
 rtl/spectro_frame_serializer.sv | 134 +++++++++++++
 tb/tb_spectro_frame_serializer.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/spectro_frame_serializer.sv
// Frame-periodic snapshot of the impulse counters, streamed out as one
// {ovf, ch_idx, count} word per channel over a valid/ready interface.
module spectro_frame_serializer #(
    parameter int N_CH         = 8,
    parameter int CNT_W        = 12,
    parameter int FRAME_CYCLES = 50000,
    parameter int SETTLE       = 2,
    parameter int CLR          = 2
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    run,
    input  logic [N_CH*CNT_W-1:0]   cnt_data,
    input  logic [N_CH-1:0]         cnt_ovf,
    output logic                    cnt_hold,
    output logic                    cnt_clear,
    output logic [15:0]             out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    out_last,
    output logic                    overrun
);

    localparam int TW = $clog2(FRAME_CYCLES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_HOLD,
        S_CAPTURE,
        S_CLEAR,
        S_STREAM
    } state_t;

    state_t             r_state;
    logic [TW-1:0]      r_timer;
    logic [7:0]         r_sub;
    logic [2:0]         r_ch;
    logic [CNT_W-1:0]   r_snap_cnt [N_CH];
    logic [N_CH-1:0]    r_snap_ovf;
    logic               w_tick;

    assign w_tick = run && (r_timer == TW'(FRAME_CYCLES - 1));

    function automatic logic [15:0] f_word(input logic [2:0] ch);
        return {r_snap_ovf[ch], ch, r_snap_cnt[ch]};
    endfunction

    always_ff @(posedge clk) begin
        if (reset || !run || w_tick) begin
            r_timer <= '0;
        end else begin
            r_timer <= r_timer + TW'(1);
        end
    end

    // Snapshot needs no reset: it is only read in STREAM, after a fresh capture.
    always_ff @(posedge clk) begin
        if (r_state == S_CAPTURE) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                r_snap_cnt[k] <= cnt_data[k*CNT_W +: CNT_W];
            end
            r_snap_ovf <= cnt_ovf;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_sub     <= '0;
            r_ch      <= '0;
            cnt_hold  <= 1'b0;
            cnt_clear <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            overrun   <= 1'b0;
        end else begin
            if (w_tick && r_state != S_IDLE) begin
                overrun <= 1'b1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_tick) begin
                        r_state  <= S_HOLD;
                        r_sub    <= '0;
                        cnt_hold <= 1'b1;
                    end
                end
                S_HOLD: begin
                    if (r_sub == 8'(SETTLE - 1)) begin
                        r_state <= S_CAPTURE;
                        r_sub   <= '0;
                    end else begin
                        r_sub <= r_sub + 8'd1;
                    end
                end
                S_CAPTURE: begin
                    r_state   <= S_CLEAR;
                    r_sub     <= '0;
                    cnt_clear <= 1'b1;
                end
                S_CLEAR: begin
                    if (r_sub == 8'(CLR - 1)) begin
                        r_state   <= S_STREAM;
                        r_sub     <= '0;
                        cnt_hold  <= 1'b0;
                        cnt_clear <= 1'b0;
                        r_ch      <= '0;
                        out_data  <= f_word(3'd0);
                        out_valid <= 1'b1;
                        out_last  <= (N_CH == 1);
                    end else begin
                        r_sub <= r_sub + 8'd1;
                    end
                end
                S_STREAM: begin
                    if (out_ready) begin
                        if (r_ch == 3'(N_CH - 1)) begin
                            r_state   <= S_IDLE;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                        end else begin
                            r_ch     <= r_ch + 3'd1;
                            out_data <= f_word(r_ch + 3'd1);
                            out_last <= ((r_ch + 3'd1) == 3'(N_CH - 1));
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spectro_frame_serializer.sv
// Directed bench for spectro_frame_serializer with a 64-cycle frame,
// SETTLE=2, CLR=2, eight channels.
module tb_spectro_frame_serializer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        run = 1'b1;
    logic [95:0] cnt_data = '0;
    logic [7:0]  cnt_ovf = '0;
    logic        cnt_hold;
    logic        cnt_clear;
    logic [15:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        out_last;
    logic        overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;

    logic [15:0] exp1 [8] = '{16'h0064, 16'h1065, 16'h2066, 16'h3067,
                              16'h4068, 16'h5069, 16'h606A, 16'h706B};
    logic [15:0] exp2 [8] = '{16'h0064, 16'h1065, 16'h2066, 16'hBFFF,
                              16'h4068, 16'h5069, 16'h606A, 16'h706B};

    spectro_frame_serializer #(
        .N_CH(8),
        .CNT_W(12),
        .FRAME_CYCLES(64),
        .SETTLE(2),
        .CLR(2)
    ) dut (
        .clk(clk),
        .reset(reset),
        .run(run),
        .cnt_data(cnt_data),
        .cnt_ovf(cnt_ovf),
        .cnt_hold(cnt_hold),
        .cnt_clear(cnt_clear),
        .out_data(out_data),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_last(out_last),
        .overrun(overrun)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got 0x%0h, expected 0x%0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic wait_valid(input string tag, input int exp_cyc);
        int guard = 0;
        while (!out_valid && guard < 200) begin
            step();
            guard++;
        end
        chk({tag, "_latency"}, cyc, exp_cyc);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, n_cmp=%0d", n_cmp);
        $fatal(1);
    end

    initial begin
        int n;
        int guard;
        logic rdy;
        logic have_held;
        logic [15:0] held;

        for (int k = 0; k < 8; k++) cnt_data[k*12 +: 12] = 12'(100 + k);

        // Test 1: basic frame timing and words
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        cyc = 0;
        chk("rst_hold", cnt_hold, 0);
        chk("rst_clear", cnt_clear, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_data", out_data, 0);
        chk("rst_overrun", overrun, 0);
        for (int c = 0; c <= 80; c++) begin
            chk("t1_hold", cnt_hold, (c >= 64 && c <= 68));
            chk("t1_clear", cnt_clear, (c >= 67 && c <= 68));
            chk("t1_valid", out_valid, (c >= 69 && c <= 76));
            if (c >= 69 && c <= 76) begin
                chk("t1_word", out_data, exp1[c-69]);
                chk("t1_last", out_last, (c == 76));
            end
            step();
        end
        chk("t1_overrun", overrun, 0);

        // Test 2: saturated count with overflow flag passes through
        cnt_data[3*12 +: 12] = 12'hFFF;
        cnt_ovf[3] = 1'b1;
        wait_valid("t2", 133);
        for (int k = 0; k < 8; k++) begin
            chk("t2_valid", out_valid, 1);
            chk("t2_word", out_data, exp2[k]);
            step();
        end
        chk("t2_end", out_valid, 0);
        cnt_data[3*12 +: 12] = 12'd103;
        cnt_ovf[3] = 1'b0;

        // Test 3: ready pattern 1,0,0,1 during stream
        wait_valid("t3", 197);
        n = 0;
        have_held = 1'b0;
        held = '0;
        for (int i = 0; i < 40 && n < 8; i++) begin
            rdy = (i % 4 == 0) || (i % 4 == 3);
            out_ready = rdy;
            chk("t3_valid", out_valid, 1);
            if (have_held) chk("t3_stable", out_data, held);
            if (rdy) begin
                chk("t3_word", out_data, exp1[n]);
                chk("t3_last", out_last, (n == 7));
                n++;
                have_held = 1'b0;
            end else begin
                held = out_data;
                have_held = 1'b1;
            end
            step();
        end
        chk("t3_count", n, 8);
        chk("t3_end", out_valid, 0);

        // Test 4: long stall drops the next tick and sets overrun
        out_ready = 1'b0;
        wait_valid("t4", 261);
        for (int i = 0; i < 100; i++) begin
            chk("t4_valid", out_valid, 1);
            chk("t4_word", out_data, exp1[0]);
            chk("t4_overrun", overrun, (cyc >= 320));
            step();
        end
        out_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("t4_drain", out_data, exp1[k]);
            step();
        end
        chk("t4_end", out_valid, 0);
        chk("t4_sticky", overrun, 1);

        // Test 5: reset during CLEAR aborts the frame
        guard = 0;
        while (!cnt_clear && guard < 100) begin
            step();
            guard++;
        end
        chk("t5_clear_at", cyc, 387);
        reset = 1'b1;
        step();
        chk("t5_hold", cnt_hold, 0);
        chk("t5_clear", cnt_clear, 0);
        chk("t5_valid", out_valid, 0);
        chk("t5_overrun", overrun, 0);
        reset = 1'b0;
        cyc = 0;
        for (int c = 0; c <= 64; c++) begin
            chk("t5_timer", cnt_hold, (c == 64));
            chk("t5_novalid", out_valid, 0);
            step();
        end
        while (cyc < 80) step();

        // Test 6: run low freezes the timer, restart gives a full frame
        run = 1'b0;
        for (int i = 0; i < 200; i++) begin
            chk("t6_hold", cnt_hold, 0);
            chk("t6_valid", out_valid, 0);
            step();
        end
        run = 1'b1;
        cyc = 0;
        for (int c = 0; c <= 64; c++) begin
            chk("t6_restart", cnt_hold, (c == 64));
            if (c < 64) step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
